// File: rtl/nn_pkg.sv
// ----------------------------------------------------------------------------
// nn_pkg -- shared definitions for the stochastic weight/bias update block.
//
// Contents:
//   state_t / ST_*     FSM state encoding (IDLE, ACCUM, UPDATE)
//   clog2()            ceiling log2, usable in constant expressions
//   cnt_width()        width of the signed up/down gradient counters
//   sat_hi()/sat_lo()  two's complement range limits for an NB-bit weight
// ----------------------------------------------------------------------------
package nn_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_ACCUM  = 2'd1;
    localparam state_t ST_UPDATE = 2'd2;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int x = v - 1; x > 0; x = x >> 1) begin
            r++;
        end
        return r;
    endfunction

    // One extra bit holds +WINLEN, another holds the sign.
    function automatic int cnt_width(input int winlen);
        return clog2(winlen) + 2;
    endfunction

    function automatic longint sat_hi(input int nb);
        return (longint'(1) << (nb - 1)) - 1;
    endfunction

    function automatic longint sat_lo(input int nb);
        return -(longint'(1) << (nb - 1));
    endfunction

endpackage

// File: rtl/nn_wb_update_if.sv
// ----------------------------------------------------------------------------
// nn_wb_update_if -- control/data bundle of nn_wb_update.
//
// Handshake: start is a one-cycle request that is accepted only while
// busy=0 and ld=0; once accepted, busy stays high through ACCUM and UPDATE
// and done pulses for exactly one cycle with the new weights already on
// alpha/beta. ld is a one-cycle request accepted only while busy=0; it wins
// over a simultaneous start. Requests presented while busy=1 are dropped,
// never queued.
//
// Signals:
//   start, dalpha[NN], dbeta, sgn, ld, ld_alpha[NN*NB], ld_beta[NB]  (to DUT)
//   alpha[NN*NB], beta[NB], busy, done, state[2] (debug FSM state)   (from DUT)
// Modports: master (stimulus side), slave (nn_wb_update).
// ----------------------------------------------------------------------------
interface nn_wb_update_if #(
    parameter int NB = 16,
    parameter int NN = 3
);
    logic               start;
    logic [NN-1:0]      dalpha;
    logic               dbeta;
    logic               sgn;
    logic               ld;
    logic [NN*NB-1:0]   ld_alpha;
    logic [NB-1:0]      ld_beta;
    logic [NN*NB-1:0]   alpha;
    logic [NB-1:0]      beta;
    logic               busy;
    logic               done;
    logic [1:0]         state;

    modport master (
        output start, dalpha, dbeta, sgn, ld, ld_alpha, ld_beta,
        input  alpha, beta, busy, done, state
    );

    modport slave (
        input  start, dalpha, dbeta, sgn, ld, ld_alpha, ld_beta,
        output alpha, beta, busy, done, state
    );
endinterface

// File: rtl/nn_wb_update_grad_counter.sv
// ----------------------------------------------------------------------------
// nn_grad_counter -- one signed up/down gradient counter plus the
// shift-and-saturate datapath that turns it into a new weight value.
//
// Ports:
//   clk, init   clock and synchronous active-high reset
//   clr         clears the counter (window start)
//   en          counting enable (ACCUM cycles)
//   bit_in      stochastic gradient bit; counts only when 1
//   sgn         0 = count up, 1 = count down
//   w           current weight
//   ld_raw      requested load value
//   w_new       sat(w - (cnt >>> LR_SHIFT))
//   ld_val      load value after range limiting
//
// Build option: NN_WB_UPDATE_CLIP_EN limits w_new and ld_val to
// [-WMAX, WMAX]; otherwise the full NB-bit two's complement range is used.
// ----------------------------------------------------------------------------
module nn_grad_counter
    import nn_pkg::*;
#(
    parameter int                    NB       = 16,
    parameter int                    WINLEN   = 256,
    parameter int                    LR_SHIFT = 4,
    parameter logic signed [NB-1:0]  WMAX     = 16'sd4096
) (
    input  logic                 clk,
    input  logic                 init,
    input  logic                 clr,
    input  logic                 en,
    input  logic                 bit_in,
    input  logic                 sgn,
    input  logic signed [NB-1:0] w,
    input  logic signed [NB-1:0] ld_raw,
    output logic signed [NB-1:0] w_new,
    output logic signed [NB-1:0] ld_val
);
    localparam int CW = cnt_width(WINLEN);
    localparam logic signed [CW-1:0] ONE = CW'(1);

`ifdef NN_WB_UPDATE_CLIP_EN
    localparam logic signed [NB:0] HI = {WMAX[NB-1], WMAX};
    localparam logic signed [NB:0] LO = -HI;
`else
    localparam logic signed [NB:0] HI = (NB+1)'(sat_hi(NB));
    localparam logic signed [NB:0] LO = (NB+1)'(sat_lo(NB));
    logic unused_wmax;
    assign unused_wmax = ^WMAX;
`endif

    function automatic logic signed [NB-1:0] sat(input logic signed [NB:0] x);
        if (x > HI)
            return HI[NB-1:0];
        else if (x < LO)
            return LO[NB-1:0];
        else
            return x[NB-1:0];
    endfunction

    logic signed [CW-1:0] cnt_q;
    logic signed [CW-1:0] cnt_sh;
    logic signed [NB:0]   w_ext;
    logic signed [NB:0]   step_ext;
    logic signed [NB:0]   diff;

    always_ff @(posedge clk) begin
        if (init || clr)
            cnt_q <= '0;
        else if (en && bit_in)
            cnt_q <= sgn ? cnt_q - ONE : cnt_q + ONE;
    end

    // Arithmetic shift floors toward minus infinity; both operands are
    // widened by one bit so the subtract itself cannot wrap.
    assign cnt_sh   = cnt_q >>> LR_SHIFT;
    assign step_ext = {{(NB+1-CW){cnt_sh[CW-1]}}, cnt_sh};
    assign w_ext    = {w[NB-1], w};
    assign diff     = w_ext - step_ext;
    assign w_new    = sat(diff);

`ifdef NN_WB_UPDATE_CLIP_EN
    assign ld_val = sat({ld_raw[NB-1], ld_raw});
`else
    assign ld_val = ld_raw;
`endif

endmodule

// File: rtl/nn_wb_update.sv
// ----------------------------------------------------------------------------
// nn_wb_update -- stochastic-bitstream weight/bias update engine.
//
// A start pulse opens a WINLEN-cycle window in which each weight's gradient
// bitstream drives a signed up/down counter. One UPDATE cycle then applies
// w <= sat(w - (cnt >>> LR_SHIFT)) to all NN alpha weights and to beta, and
// done pulses in the following (IDLE) cycle with the new values visible.
//
// Ports:
//   CLK    sole clock, rising edge
//   INIT   synchronous active-high reset (state, counters, weights, done)
//   bus    nn_wb_update_if.slave: start, dalpha, dbeta, sgn, ld, ld_alpha,
//          ld_beta in; alpha, beta, busy, done, state (debug) out
//
// Build option: NN_WB_UPDATE_CLIP_EN limits updated and loaded weights to
// [-WMAX, WMAX].
// ----------------------------------------------------------------------------
module nn_wb_update
    import nn_pkg::*;
#(
    parameter int                    NB       = 16,
    parameter int                    NN       = 3,
    parameter int                    WINLEN   = 256,
    parameter int                    LR_SHIFT = 4,
    parameter logic signed [NB-1:0]  WMAX     = 16'sd4096
) (
    input  logic           CLK,
    input  logic           INIT,
    nn_wb_update_if.slave  bus
);
    localparam int WW = clog2(WINLEN);
    localparam logic [WW-1:0] WIN_LAST = WW'(WINLEN - 1);
    localparam logic [WW-1:0] WIN_ONE  = WW'(1);

    state_t               state_q;
    logic [WW-1:0]        win_q;
    logic                 done_q;
    logic signed [NB-1:0] w_q    [NN+1];
    logic signed [NB-1:0] w_new  [NN+1];
    logic signed [NB-1:0] ld_raw [NN+1];
    logic signed [NB-1:0] ld_val [NN+1];
    logic [NN:0]          bits;
    logic                 is_idle;
    logic                 is_accum;
    logic                 go;

    assign is_idle  = (state_q == ST_IDLE);
    assign is_accum = (state_q == ST_ACCUM);
    // ld has priority over start in the same IDLE cycle.
    assign go       = is_idle && bus.start && !bus.ld;
    // Slot NN is beta; slots 0..NN-1 are alpha.
    assign bits     = {bus.dbeta, bus.dalpha};

    for (genvar g = 0; g <= NN; g++) begin : g_cnt
        if (g < NN) begin : g_alpha
            assign ld_raw[g] = bus.ld_alpha[g*NB +: NB];
            assign bus.alpha[g*NB +: NB] = w_q[g];
        end else begin : g_beta
            assign ld_raw[g] = bus.ld_beta;
            assign bus.beta  = w_q[g];
        end

        nn_grad_counter #(
            .NB       (NB),
            .WINLEN   (WINLEN),
            .LR_SHIFT (LR_SHIFT),
            .WMAX     (WMAX)
        ) u_cnt (
            .clk    (CLK),
            .init   (INIT),
            .clr    (go),
            .en     (is_accum),
            .bit_in (bits[g]),
            .sgn    (bus.sgn),
            .w      (w_q[g]),
            .ld_raw (ld_raw[g]),
            .w_new  (w_new[g]),
            .ld_val (ld_val[g])
        );
    end

    always_ff @(posedge CLK) begin
        if (INIT) begin
            state_q <= ST_IDLE;
            win_q   <= '0;
            done_q  <= 1'b0;
            for (int i = 0; i <= NN; i++) w_q[i] <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bus.ld) begin
                        for (int i = 0; i <= NN; i++) w_q[i] <= ld_val[i];
                    end else if (bus.start) begin
                        state_q <= ST_ACCUM;
                        win_q   <= '0;
                    end
                end
                ST_ACCUM: begin
                    win_q <= win_q + WIN_ONE;
                    if (win_q == WIN_LAST) state_q <= ST_UPDATE;
                end
                ST_UPDATE: begin
                    for (int i = 0; i <= NN; i++) w_q[i] <= w_new[i];
                    done_q  <= 1'b1;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.busy  = !is_idle;
    assign bus.done  = done_q;
    assign bus.state = state_q;

endmodule

// File: tb/tb_nn_wb_update.sv
// ----------------------------------------------------------------------------
// tb_nn_wb_update -- directed bench for nn_wb_update (NB=16, NN=3,
// WINLEN=16, LR_SHIFT=2). Expected weights are hand-computed from
// w_new = sat(w - (cnt >>> 2)). Honours NN_WB_UPDATE_CLIP_EN (WMAX=100).
// ----------------------------------------------------------------------------
module tb_nn_wb_update;
    import nn_pkg::*;

    localparam int NB = 16, NN = 3, WINLEN = 16, LR_SHIFT = 2;
`ifdef NN_WB_UPDATE_CLIP_EN
    localparam logic signed [NB-1:0] WMAX = 16'sd100;
    localparam int LD_HI = 98, LD_LO = -98, SAT_HI = 100, SAT_LO = -100;
`else
    localparam logic signed [NB-1:0] WMAX = 16'sd4096;
    localparam int LD_HI = 32766, LD_LO = -32767, SAT_HI = 32767, SAT_LO = -32768;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic init;
    always #5 clk = ~clk;

    nn_wb_update_if #(.NB(NB), .NN(NN)) bus ();

    nn_wb_update #(
        .NB(NB), .NN(NN), .WINLEN(WINLEN), .LR_SHIFT(LR_SHIFT), .WMAX(WMAX)
    ) dut (
        .CLK  (clk),
        .INIT (init),
        .bus  (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    // ---------------- checking ----------------
    task automatic check_val(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int get_w(input int n);
        int v;
        if (n < NN) v = $signed(bus.alpha[n*NB +: NB]);
        else        v = $signed(bus.beta);
        return v;
    endfunction

    task automatic check_w(input string tag, input int a0, input int a1,
                           input int a2, input int b);
        check_val({tag, "_a0"},   get_w(0), a0);
        check_val({tag, "_a1"},   get_w(1), a1);
        check_val({tag, "_a2"},   get_w(2), a2);
        check_val({tag, "_beta"}, get_w(3), b);
    endtask

    // ---------------- drivers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        bus.start    = 1'b0;
        bus.dalpha   = '0;
        bus.dbeta    = 1'b0;
        bus.sgn      = 1'b0;
        bus.ld       = 1'b0;
        bus.ld_alpha = '0;
        bus.ld_beta  = '0;
    endtask

    task automatic do_load(input int a0, input int a1, input int a2, input int b);
        bus.ld       = 1'b1;
        bus.ld_alpha = {NB'(a2), NB'(a1), NB'(a0)};
        bus.ld_beta  = NB'(b);
        tick();
        bus.ld       = 1'b0;
    endtask

    // Start pulse, 16 cycles of bitstream, then measure start-to-done latency.
    task automatic run_window(input string tag, input logic [2:0] da,
                              input logic db, input logic [15:0] sgn_pat);
        int cyc;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check_val({tag, "_busy"}, int'(bus.busy), 1);
        for (int i = 0; i < WINLEN; i++) begin
            bus.dalpha = da;
            bus.dbeta  = db;
            bus.sgn    = sgn_pat[i];
            tick();
        end
        bus.dalpha = '0;
        bus.dbeta  = 1'b0;
        bus.sgn    = 1'b0;
        cyc = WINLEN + 1;
        while (bus.done !== 1'b1 && cyc < 40) begin
            tick();
            cyc++;
        end
        check_val({tag, "_latency"}, cyc, WINLEN + 2);
        tick();
        check_val({tag, "_done_drop"}, int'(bus.done), 0);
        check_val({tag, "_idle"}, int'(bus.busy), 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n_done;
        int done_at;

        drive_idle();
        init = 1'b1;
        tick();
        init = 1'b0;

        // reset state
        check_w("rst", 0, 0, 0, 0);
        check_val("rst_busy",  int'(bus.busy),  0);
        check_val("rst_done",  int'(bus.done),  0);
        check_val("rst_state", int'(bus.state), int'(ST_IDLE));

        // alpha[0] counts up 16 -> step 4
        run_window("alpha", 3'b001, 1'b0, 16'h0000);
        check_w("alpha", -4, 0, 0, 0);

        // beta near +limit, counts down 16 -> +4 -> saturates high
        do_load(0, 0, 0, LD_HI);
        check_val("ld_hi_beta", get_w(3), LD_HI);
        run_window("bsat_hi", 3'b000, 1'b1, 16'hFFFF);
        check_w("bsat_hi", 0, 0, 0, SAT_HI);

        // beta near -limit, counts up 16 -> -4 -> saturates low
        do_load(0, 0, 0, LD_LO);
        run_window("bsat_lo", 3'b000, 1'b1, 16'h0000);
        check_w("bsat_lo", 0, 0, 0, SAT_LO);

        // mixed sign: -10 + 6 = -4, >>>2 = -1, alpha[1] = 0 - (-1) = 1
        do_load(0, 0, 0, 0);
        run_window("mixed", 3'b010, 1'b0, 16'h03FF);
        check_w("mixed", 0, 1, 0, 0);

        // INIT during ACCUM cycle 5
        do_load(5, 6, 7, 9);
        check_w("ld", 5, 6, 7, 9);
        bus.start = 1'b1;
        tick();
        bus.start  = 1'b0;
        bus.dalpha = 3'b111;
        bus.dbeta  = 1'b1;
        repeat (4) tick();
        check_val("mid_state", int'(bus.state), int'(ST_ACCUM));
        init = 1'b1;
        tick();
        init = 1'b0;
        bus.dalpha = '0;
        bus.dbeta  = 1'b0;
        check_val("mid_rst_state", int'(bus.state), int'(ST_IDLE));
        check_val("mid_rst_busy",  int'(bus.busy),  0);
        check_w("mid_rst", 0, 0, 0, 0);
        n_done = 0;
        repeat (25) begin
            tick();
            if (bus.done === 1'b1) n_done++;
        end
        check_val("mid_rst_no_done", n_done, 0);
        check_w("mid_rst_hold", 0, 0, 0, 0);

        // start and ld while busy are ignored; exactly one done
        do_load(11, 12, 13, 14);
        n_done  = 0;
        done_at = -1;
        for (int i = 0; i < 40; i++) begin
            bus.start    = (i == 0 || i == 3 || i == 17);
            bus.ld       = (i == 5);
            bus.ld_alpha = '1;
            bus.ld_beta  = '1;
            tick();
            if (bus.done === 1'b1) begin
                n_done++;
                done_at = i;
            end
        end
        drive_idle();
        check_val("busy_start_ndone", n_done, 1);
        check_val("busy_start_at", done_at, WINLEN + 1);
        check_w("busy_ld", 11, 12, 13, 14);

        // ld and start together: load wins, FSM stays idle
        bus.ld       = 1'b1;
        bus.start    = 1'b1;
        bus.ld_alpha = {NB'(70), NB'(-60), NB'(50)};
        bus.ld_beta  = NB'(-80);
        tick();
        drive_idle();
        check_val("ldst_busy",  int'(bus.busy),  0);
        check_val("ldst_state", int'(bus.state), int'(ST_IDLE));
        check_w("ldst", 50, -60, 70, -80);
        tick();
        check_val("ldst_busy2", int'(bus.busy), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
